// File: rtl/store_writer.sv
// Store write-side formatter and in-order store buffer.
// Aligns store data to byte lanes and issues writes on the dbus.
module store_writer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_data,
    input  logic [2:0]  in_msize,
    input  logic        flush,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [63:0] dreq_data,
    output logic [7:0]  dreq_strobe,
    output logic [2:0]  dreq_msize,
    input  logic        dresp_data_ok,
    output logic        store_done,
    output logic        misalign_err,
    output logic [63:0] err_addr,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strobe;
        logic [2:0]  msize;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        new_e;
    entry_t        head_e;
    logic [PW-1:0] head, tail, head_n, tail_n;
    logic [CW-1:0] count, count_n;
    logic          legal, accept, push, pop, bad;
    logic [7:0]    base;

    // Size/alignment legality and the base strobe pattern of the request.
    always_comb begin
        legal = 1'b0;
        base  = 8'h00;
        unique case (in_msize)
            3'd0: begin legal = 1'b1;                base = 8'h01; end
            3'd1: begin legal = ~in_addr[0];         base = 8'h03; end
            3'd2: begin legal = in_addr[1:0] == 2'b0; base = 8'h0F; end
            3'd3: begin legal = in_addr[2:0] == 3'b0; base = 8'hFF; end
            default: begin legal = 1'b0;             base = 8'h00; end
        endcase
    end

    // Lane formatting is done once at enqueue and stored with the entry.
    always_comb begin
        new_e.addr   = {in_addr[63:3], 3'b000};
        new_e.data   = in_data << {in_addr[2:0], 3'b000};
        new_e.strobe = base << in_addr[2:0];
        new_e.msize  = in_msize;
    end

    assign empty      = (count == '0);
    assign in_ready   = (count < DEPTH_C);
    assign accept     = in_valid && in_ready;
    assign push       = accept && legal && !(flush && !empty);
    assign bad        = accept && !legal;
    assign pop        = dresp_data_ok && !empty;
    assign dreq_valid = !empty;
    assign head_e     = mem[head];

    assign dreq_addr   = dreq_valid ? head_e.addr   : 64'd0;
    assign dreq_data   = dreq_valid ? head_e.data   : 64'd0;
    assign dreq_strobe = dreq_valid ? head_e.strobe : 8'd0;
    assign dreq_msize  = dreq_valid ? head_e.msize  : 3'd0;

    // Next pointer/count; flush keeps only the entry already on the bus.
    always_comb begin
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        if (pop) head_n = head + PW'(1);
        if (flush && !empty) begin
            tail_n  = head + PW'(1);
            count_n = pop ? CW'(0) : CW'(1);
        end else begin
            if (push) tail_n = tail + PW'(1);
            count_n = count + CW'(push) - CW'(pop);
        end
    end

    // Buffer storage; contents are don't-care while not counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= new_e;
    end

    // Control state, completion and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            store_done   <= 1'b0;
            misalign_err <= 1'b0;
            err_addr     <= 64'd0;
        end else begin
            head         <= head_n;
            tail         <= tail_n;
            count        <= count_n;
            store_done   <= pop;
            misalign_err <= bad;
            if (bad) err_addr <= in_addr;
        end
    end

endmodule
